// File: rtl/btn_debounce_if.sv
// Button pin / debounced-event bundle shared by the debouncer and its consumers.
// slave = debouncer side (takes raw pins, drives events); master = pin/consumer side.
interface btn_debounce_if #(
  parameter int NUM_BTN = 5
);
  logic [NUM_BTN-1:0] user_btn;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_long;

  modport master (
    output user_btn,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  user_btn,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-button 2-flop synchronizer plus stability counter, giving a clean level and press/release pulses.
// Optional long-press detection is compiled in with `define BTN_LONG_PRESS_EN.
module btn_debounce #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1562500,
  parameter int LONG_CYCLES     = 312500000
) (
  input  logic           clk156,
  input  logic           rst_n,
  btn_debounce_if.slave  btn
);

`ifdef BTN_LONG_PRESS_EN
  localparam bit USE_LONG = 1'b1;
`else
  localparam bit USE_LONG = 1'b0;
`endif

  localparam int CNT_SPAN = (USE_LONG && (LONG_CYCLES > DEBOUNCE_CYCLES)) ? LONG_CYCLES
                                                                          : DEBOUNCE_CYCLES;
  localparam int CNT_W = (CNT_SPAN < 1) ? 1 : $clog2(CNT_SPAN + 1);

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_BTN-1:0] sync_p0;
  logic [NUM_BTN-1:0] sync_p1;

  logic [NUM_BTN-1:0] level_q,   level_d;
  logic [NUM_BTN-1:0] press_q,   press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  // Stage p0/p1: metastability synchronizer; only sync_p1 feeds the filter
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn.user_btn;
      sync_p1 <= sync_p0;
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive samples disagree with the level
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync_p1[i] != level_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          level_d[i]   = sync_p1[i];
          press_d[i]   = sync_p1[i];
          release_d[i] = ~sync_p1[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Stage p2: registered level, event pulses and stability counters
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_DONE = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0]   hold_q [NUM_BTN];
  logic [CNT_W-1:0]   hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] long_q, long_d;

  // Hold counter parks at LONG_CYCLES after firing, so one press yields one long pulse
  always_comb begin
    long_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_d[i] = '0;
      if (level_q[i]) begin
        hold_d[i] = hold_q[i];
        if (hold_q[i] != LONG_DONE) hold_d[i] = hold_q[i] + CNT_ONE;
        long_d[i] = (hold_q[i] == LONG_MAX);
      end
    end
  end

  // Stage p2 (long press): registered hold counters and pulse
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign btn.btn_long = long_q;
`else
  assign btn.btn_long = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=8, NUM_BTN=5.
module tb_btn_debounce;
  localparam int NB = 5;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [NB-1:0] LONG_HIT = 5'b00001;
`else
  localparam logic [NB-1:0] LONG_HIT = 5'b00000;
`endif

  logic clk156;
  logic rst_n;
  int   passed;
  int   total;

  btn_debounce_if #(.NUM_BTN(NB)) bif ();

  btn_debounce #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (8)
  ) dut (
    .clk156(clk156),
    .rst_n (rst_n),
    .btn   (bif.slave)
  );

  initial begin
    clk156 = 1'b0;
    forever #10 clk156 = ~clk156;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk156);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [NB-1:0] lvl, input logic [NB-1:0] prs,
                         input logic [NB-1:0] rel, input logic [NB-1:0] lng);
    chk({tag, ".level"},   bif.btn_level,   lvl);
    chk({tag, ".press"},   bif.btn_press,   prs);
    chk({tag, ".release"}, bif.btn_release, rel);
    chk({tag, ".long"},    bif.btn_long,    lng);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst_n        = 1'b0;
    bif.user_btn = 5'b11111;

    // Reset with every button held: outputs stay 0, then a fresh press after release
    step(); step(); step();
    chk_all("rst_hold", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all("rst_wait", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    end
    step();
    chk_all("rst_press", 5'b11111, 5'b11111, 5'b00000, 5'b00000);
    step();
    chk_all("rst_after", 5'b11111, 5'b00000, 5'b00000, 5'b00000);
    bif.user_btn = 5'b00000;
    repeat (5) step();
    chk_all("rst_rel_wait", 5'b11111, 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("rst_release", 5'b00000, 5'b00000, 5'b11111, 5'b00000);
    step();
    chk_all("rst_rel_after", 5'b00000, 5'b00000, 5'b00000, 5'b00000);

    // Clean press on btn0 held 20 cycles: press at edge 6, long 8 edges after press
    bif.user_btn = 5'b00001;
    repeat (5) step();
    chk_all("p0_wait", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("p0_press", 5'b00001, 5'b00001, 5'b00000, 5'b00000);
    step();
    chk_all("p0_after", 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    repeat (6) step();
    chk_all("p0_long_pre", 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("p0_long", 5'b00001, 5'b00000, 5'b00000, LONG_HIT);
    step();
    chk_all("p0_long_post", 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("p0_no_repeat", bif.btn_long, 5'b00000);
    end
    bif.user_btn = 5'b00000;
    repeat (5) step();
    chk_all("p0_rel_wait", 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("p0_release", 5'b00000, 5'b00000, 5'b00001, 5'b00000);
    step();
    chk_all("p0_rel_after", 5'b00000, 5'b00000, 5'b00000, 5'b00000);

    // Bounce on btn1 (1,0,1,0) then held: one press, 4 stable cycles after the last bounce
    bif.user_btn = 5'b00010; step();
    bif.user_btn = 5'b00000; step();
    bif.user_btn = 5'b00010; step();
    bif.user_btn = 5'b00000; step();
    bif.user_btn = 5'b00010;
    for (int k = 5; k <= 9; k++) begin
      step();
      chk_all("b1_bounce", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    end
    step();
    chk_all("b1_press", 5'b00010, 5'b00010, 5'b00000, 5'b00000);
    step();
    chk_all("b1_after", 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    bif.user_btn = 5'b00000;
    repeat (8) step();
    chk_all("b1_released", 5'b00000, 5'b00000, 5'b00000, 5'b00000);

    // Glitch on btn2: only 3 cycles high, must be rejected
    bif.user_btn = 5'b00100;
    repeat (3) step();
    bif.user_btn = 5'b00000;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all("g2_reject", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    end

    // btn3 and btn4 pressed together: pulses land in the same cycle
    bif.user_btn = 5'b11000;
    repeat (5) step();
    chk_all("s34_wait", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("s34_press", 5'b11000, 5'b11000, 5'b00000, 5'b00000);
    step();
    chk_all("s34_after", 5'b11000, 5'b00000, 5'b00000, 5'b00000);
    bif.user_btn = 5'b00000;
    repeat (6) step();
    chk_all("s34_release", 5'b00000, 5'b00000, 5'b11000, 5'b00000);
    step();

    // Async reset at cnt=2 on btn0: progress discarded, fresh latency after reset release
    bif.user_btn = 5'b00001;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk_all("ar_assert", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("ar_hold1", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("ar_hold2", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all("ar_wait", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    end
    step();
    chk_all("ar_press", 5'b00001, 5'b00001, 5'b00000, 5'b00000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
